// File: rtl/lcd_cmd_arbiter.sv
// Two-requester round-robin command arbiter and sequencer for the LCD window controller.
// Streams load bytes, returns tagged window beats and aborts via a watchdog on a stalled LCD.
module lcd_cmd_arbiter #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned NLOAD   = 36,
   parameter int unsigned NBEAT   = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [2:0] req0_cmd,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   output logic       req0_data_ack,
   input  logic       req1_valid,
   input  logic [2:0] req1_cmd,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       req1_data_ack,
   output logic [2:0] lcd_cmd,
   output logic       lcd_cmd_valid,
   output logic [7:0] lcd_datain,
   input  logic       lcd_busy,
   input  logic [7:0] lcd_dataout,
   input  logic       lcd_output_valid,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_id,
   output logic       rsp_last,
   output logic       rsp_err,
   output logic       arb_busy
);

   localparam logic [5:0] LoadLast = 6'(NLOAD - 1);
   localparam logic [7:0] WdLast   = 8'(TIMEOUT - 1);
   localparam logic [3:0] BeatLast = 4'(NBEAT - 1);
   localparam logic [2:0] CmdLoad  = 3'd1;

   typedef enum logic [2:0] {StIdle, StIssue, StLoad, StWaitOut, StDrain} state_e;

   state_e     state_q, state_d;
   logic       gid_q, gid_d;
   logic       ptr_q, ptr_d;
   logic [2:0] cmd_q, cmd_d;
   logic [5:0] load_cnt_q, load_cnt_d;
   logic [7:0] wd_q, wd_d;
   logic [3:0] beat_cnt_q, beat_cnt_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       rsp_id_q, rsp_id_d;
   logic       rsp_last_q, rsp_last_d;
   logic       rsp_err_q, rsp_err_d;

   logic       win;
   logic [2:0] win_cmd;

   // Round-robin pick: a lone requester wins, otherwise ptr decides.
   always_comb begin
      win = req1_valid;
      if (req0_valid && req1_valid) begin
         win = ptr_q;
      end
      win_cmd = win ? req1_cmd : req0_cmd;
   end

   always_comb begin
      state_d     = state_q;
      gid_d       = gid_q;
      ptr_d       = ptr_q;
      cmd_d       = cmd_q;
      load_cnt_d  = load_cnt_q;
      wd_d        = wd_q;
      beat_cnt_d  = beat_cnt_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_id_d    = rsp_id_q;
      rsp_last_d  = 1'b0;
      rsp_err_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!lcd_busy && (req0_valid || req1_valid)) begin
               gid_d   = win;
               ptr_d   = ~win;
               // Undefined codes 6 and 7 are issued as reflash.
               cmd_d   = (win_cmd > 3'd5) ? 3'd0 : win_cmd;
               state_d = StIssue;
            end
         end
         StIssue: begin
            load_cnt_d = '0;
            wd_d       = '0;
            beat_cnt_d = '0;
            state_d    = (cmd_q == CmdLoad) ? StLoad : StWaitOut;
         end
         StLoad: begin
            if (load_cnt_q == LoadLast) begin
               load_cnt_d = '0;
               wd_d       = '0;
               state_d    = StWaitOut;
            end else begin
               load_cnt_d = load_cnt_q + 6'd1;
            end
         end
         StWaitOut: begin
            if (lcd_output_valid) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = lcd_dataout;
               rsp_id_d    = gid_q;
               wd_d        = '0;
               if (beat_cnt_q == BeatLast) begin
                  rsp_last_d = 1'b1;
                  beat_cnt_d = '0;
                  state_d    = StDrain;
               end else begin
                  beat_cnt_d = beat_cnt_q + 4'd1;
               end
            end else if (wd_q == WdLast) begin
               rsp_err_d  = 1'b1;
               rsp_id_d   = gid_q;
               wd_d       = '0;
               beat_cnt_d = '0;
               state_d    = StIdle;
            end else begin
               wd_d = wd_q + 8'd1;
            end
         end
         StDrain: begin
            if (!lcd_busy) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         gid_q       <= 1'b0;
         ptr_q       <= 1'b0;
         cmd_q       <= '0;
         load_cnt_q  <= '0;
         wd_q        <= '0;
         beat_cnt_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         gid_q       <= gid_d;
         ptr_q       <= ptr_d;
         cmd_q       <= cmd_d;
         load_cnt_q  <= load_cnt_d;
         wd_q        <= wd_d;
         beat_cnt_q  <= beat_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_id_q    <= rsp_id_d;
         rsp_last_q  <= rsp_last_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_comb begin
      lcd_cmd_valid = (state_q == StIssue);
      req0_ready    = lcd_cmd_valid && !gid_q;
      req1_ready    = lcd_cmd_valid && gid_q;
      req0_data_ack = (state_q == StLoad) && !gid_q;
      req1_data_ack = (state_q == StLoad) && gid_q;
      lcd_datain    = '0;
      if (state_q == StLoad) begin
         lcd_datain = gid_q ? req1_data : req0_data;
      end
   end

   // cmd_q only changes on a grant, so lcd_cmd holds between strobes.
   assign lcd_cmd   = cmd_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_last  = rsp_last_q;
   assign rsp_err   = rsp_err_q;
   assign arb_busy  = (state_q != StIdle);

endmodule

// File: doc/lcd_cmd_arbiter.md
# lcd_cmd_arbiter

Two-port command arbiter and sequencer in front of the 6x6-image LCD window controller. It grants one of two host requesters at a time using round-robin order and issues that requester's command to the LCD controller. For a load command it streams the 36 image bytes from that requester, then routes the 9 returned window bytes back to the requester, tagged with its ID. A watchdog recovers the arbiter if the LCD controller never returns data.

## Interface
- TIMEOUT, 64: maximum cycles in WAIT_OUT without an output beat before abort; legal range 2..255.
- NLOAD, 36: bytes streamed for a load command.
- NBEAT, 9: window bytes returned per command.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req0_valid / req1_valid  in  1  requester has a command pending; held until its ready.
- req0_cmd / req1_cmd  in  3  0 reflash, 1 load, 2 right, 3 left, 4 up, 5 down.
- req0_data / req1_data  in  8  load byte; must be valid in every cycle the matching data_ack is high.
- req0_ready / req1_ready  out  1  one-cycle pulse: command accepted.
- req0_data_ack / req1_data_ack  out  1  load byte consumed this cycle.
- lcd_cmd  out  3  command to LCD controller.
- lcd_cmd_valid  out  1  one-cycle command strobe.
- lcd_datain  out  8  load byte to LCD controller.
- lcd_busy  in  1  LCD controller busy.
- lcd_dataout  in  8  window byte from LCD controller.
- lcd_output_valid  in  1  lcd_dataout valid.
- rsp_valid  out  1  rsp_data valid.
- rsp_data  out  8  returned window byte.
- rsp_id  out  1  owner of rsp_*; 0 = req0, 1 = req1.
- rsp_last  out  1  marks the 9th beat.
- rsp_err  out  1  one-cycle pulse: watchdog abort for rsp_id.
- arb_busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, LOAD, WAIT_OUT, DRAIN.
- **IDLE**
  - Arbitration runs when lcd_busy = 0 and at least one reqN_valid is high.
  - If only one requester is valid, it wins.
  - If both are valid, the priority pointer `ptr` decides (reset value 0).
  - On a grant: latch `gid` and the command; set `ptr` to the other requester; go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - lcd_cmd_valid = 1 and lcd_cmd = latched command.
  - Command codes 6 and 7 are issued as 0.
  - req[gid]_ready = 1.
  - Next state: LOAD if the command is 1, otherwise WAIT_OUT.
- **LOAD**
  - Runs exactly NLOAD cycles; a 6-bit counter counts 0..NLOAD-1.
  - req[gid]_data_ack = 1 in every LOAD cycle; lcd_datain = req[gid]_data, combinational.
  - Outside LOAD, all data_ack outputs are 0 and lcd_datain = 0.
  - After the last byte, go to WAIT_OUT.
- **WAIT_OUT**
  - Each cycle with lcd_output_valid = 1 is one beat: registered rsp_valid = 1, rsp_data = lcd_dataout, rsp_id = gid.
  - An 8-bit watchdog counter clears on entry and on every beat, and increments otherwise.
  - On the NBEAT-th beat, rsp_last = 1 and the next state is DRAIN.
  - lcd_output_valid is ignored outside WAIT_OUT.
- **DRAIN**
  - Wait until lcd_busy = 0, then go to IDLE.
- **Watchdog abort**
  - Triggers when the watchdog counter reaches TIMEOUT-1 with no beat in that cycle.
  - rsp_err pulses for 1 cycle with rsp_id = gid; no rsp_last is produced; the next state is IDLE.
- **Reset**
  - Applies at any time, including mid-LOAD.
  - All outputs return to 0; state = IDLE; ptr = 0; all counters = 0.
  - A transfer interrupted by reset is not resumed.
- lcd_cmd holds its last value while lcd_cmd_valid = 0.

## Timing
- If a grant decision occurs in cycle T (IDLE):
  - ISSUE, lcd_cmd_valid and reqN_ready are all in cycle T+1.
  - For a load, data_ack is high in cycles T+2..T+37 and WAIT_OUT begins at T+38.
  - For a non-load command, WAIT_OUT begins at T+2.
- rsp_* lag lcd_output_valid/lcd_dataout by exactly 1 cycle.
- At least 1 IDLE cycle separates consecutive grants.
- reqN_valid is sampled only in IDLE; a requester deasserting before its ready is never granted.

## Test plan
- **Reset:** assert reset mid-LOAD at byte 10 -> all outputs 0 in the next cycle, data_ack low, arb_busy 0; ptr = 0.
- **Single reflash:** req0 cmd 0; LCD model returns 0x11..0x19 -> req0_ready and lcd_cmd_valid at T+1 with lcd_cmd = 0; rsp_data 0x11..0x19 each one cycle after its lcd beat, rsp_id 0, rsp_last only on 0x19.
- **Load:** req1 cmd 1 with bytes 0..35 -> req1_data_ack high for exactly 36 cycles T+2..T+37; lcd_datain = 0..35 in order; req0_data_ack stays 0.
- **Arbitration:** req0 and req1 both hold valid continuously -> grant order req0, req1, req0, req1; with only req1 valid twice -> req1 granted both times.
- **Watchdog (TIMEOUT 64):** LCD model never emits output_valid after cmd 2 -> rsp_err pulses for one cycle 64 cycles after WAIT_OUT entry; no rsp_valid; arb_busy 0 the next cycle.
- **Illegal command:** req0 cmd 7 -> lcd_cmd = 0 with lcd_cmd_valid; the normal 9-beat response follows.
